// File: rtl/bcd_counter_display.sv
// -----------------------------------------------------------------------------
// bcd_counter_display
//
// Purpose:
//   This block is a multi-digit BCD up/down counter that saturates at its
//   terminal value. It includes a free-running tick prescaler and a
//   time-multiplexed 7-segment scanner that drives the board pins directly.
//
// Parameters:
//   DIGITS   number of BCD digits counted and displayed (1..8)
//   CLK_HZ   input clock frequency
//   TICK_HZ  count rate        (TICK_DIV = CLK_HZ/TICK_HZ, >= 2)
//   SCAN_HZ  per-digit scan rate (SCAN_DIV = CLK_HZ/SCAN_HZ, >= 2)
//
// Ports:
//   clk_100MHz  in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   enable      in   1 = count on each tick, 0 = hold
//   forward     in   1 = count up, 0 = count down
//   load        in   synchronous load of load_value (wins over a tick)
//   load_value  in   BCD digits; digit 0 = [3:0]; digits > 9 load as 9
//   count       out  registered BCD count
//   finish      out  count is at the terminal value for the current direction
//   seg         out  {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low, always off
//   an          out  digit anodes, active-low, one-hot-low
//
// Configuration macro:
//   LEADING_ZERO_BLANK_EN - when this macro is defined, a digit above digit 0
//   is blanked if it and all higher digits are zero. The anode timing does
//   not change.
// -----------------------------------------------------------------------------
module bcd_counter_display #(
    parameter int DIGITS  = 4,
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int SCAN_HZ = 1000
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  forward,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  finish,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam int SCAN_W   = $clog2(SCAN_DIV);
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW       = 4 * DIGITS;

    // Map an active-low 7-segment pattern, {g,f,e,d,c,b,a}. Non-BCD values are shown blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    // Step the count by one BCD unit, rippling the carry or borrow across digits.
    // The caller never steps past all-9s or all-0s, so the top digit cannot overflow.
    function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] val, input logic up);
        logic [CW-1:0] res;
        logic          ripple;
        logic [3:0]    d;
        res    = val;
        ripple = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = val[4*i +: 4];
            if (ripple) begin
                if (up) begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d      = d + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d      = d - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
            res[4*i +: 4] = d;
        end
        return res;
    endfunction

    // Clamp each loaded digit to 9 so that the count never holds a non-BCD digit.
    function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] val);
        logic [CW-1:0] res;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = (val[4*i +: 4] > 4'd9) ? 4'd9 : val[4*i +: 4];
        end
        return res;
    endfunction

    logic [TICK_W-1:0] presc_r;
    logic [SCAN_W-1:0] scan_cnt_r;
    logic [IDX_W-1:0]  scan_idx_r;
    logic [CW-1:0]     count_r;
    logic [6:0]        seg_r;
    logic [DIGITS-1:0] an_r;
    logic              tick_s;
    logic              finish_s;
    logic [3:0]        scan_digit_s;
    logic              blank_s;

    assign tick_s = (presc_r == TICK_W'(TICK_DIV - 1));

    // Free-running prescaler. Enable and load do not gate it.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + TICK_W'(1);
        end
    end

    // Decode the terminal value for the current direction from the registered count.
    always_comb begin
        finish_s = 1'b0;
        if (forward) begin
            finish_s = (count_r == {DIGITS{4'd9}});
        end else begin
            finish_s = (count_r == {DIGITS{4'd0}});
        end
    end

    // Count register. Load has priority over a tick, and a tick at the terminal value does nothing.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= bcd_clamp(load_value);
        end else if (tick_s && enable && !finish_s) begin
            count_r <= bcd_step(count_r, forward);
        end else begin
            count_r <= count_r;
        end
    end

    // Scan timing: the index advances once every SCAN_DIV cycles and wraps from the last digit to 0.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            scan_cnt_r <= '0;
            scan_idx_r <= '0;
        end else if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_r <= '0;
            if (scan_idx_r == IDX_W'(DIGITS - 1)) begin
                scan_idx_r <= '0;
            end else begin
                scan_idx_r <= scan_idx_r + IDX_W'(1);
            end
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            scan_idx_r <= scan_idx_r;
        end
    end

    // Select the digit under the scan index and decide whether to blank it as a leading zero.
    always_comb begin
        scan_digit_s = 4'd0;
        blank_s      = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_r == IDX_W'(i)) begin
                scan_digit_s = count_r[4*i +: 4];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                zero_above = zero_above & (count_r[4*i +: 4] == 4'd0);
                if ((scan_idx_r == IDX_W'(i)) && zero_above) begin
                    blank_s = 1'b1;
                end
            end
        end
`else
        blank_s = 1'b0;
`endif
    end

    // Register the anode and segment outputs together so that a digit always shows its own pattern.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            an_r  <= ~DIGITS'(1);
            seg_r <= 7'b1000000;
        end else begin
            an_r  <= ~(DIGITS'(1) << scan_idx_r);
            seg_r <= blank_s ? 7'h7F : seg7_decode(scan_digit_s);
        end
    end

    assign count  = count_r;
    assign finish = finish_s;
    assign seg    = seg_r;
    assign an     = an_r;
    assign dp     = 1'b1;

endmodule

// File: tb/tb_bcd_counter_display.sv
module tb_bcd_counter_display;

    localparam int DIGITS = 2;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        enable;
    logic        forward;
    logic        load;
    logic [7:0]  load_value;
    logic [7:0]  count;
    logic        finish;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  an;

    int checks_total  = 0;
    int checks_passed = 0;

    // The reference model holds the count as a plain integer from 0 to 99.
    int         m_val;
    int         m_presc;
    int         m_scan;
    int         m_idx;
    logic [1:0] m_an;
    logic [6:0] m_seg;
    logic [6:0] pat [10];

    always #5 clk_100MHz = ~clk_100MHz;

    bcd_counter_display #(
        .DIGITS  (DIGITS),
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .SCAN_HZ (50)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .enable     (enable),
        .forward    (forward),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .finish     (finish),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int clamp_load(input logic [7:0] v);
        int t;
        int o;
        t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit m_finish();
        return forward ? (m_val == 99) : (m_val == 0);
    endfunction

    task automatic model_reset();
        m_val   = 0;
        m_presc = 0;
        m_scan  = 0;
        m_idx   = 0;
        m_an    = 2'b10;
        m_seg   = 7'b1000000;
    endtask

    // Model one clock edge. The display registers sample the state that exists before the edge.
    task automatic model_step();
        bit tk;
        int d;
        d     = (m_idx == 0) ? (m_val % 10) : (m_val / 10);
        m_an  = (m_idx == 0) ? 2'b10 : 2'b01;
        m_seg = pat[d];
`ifdef LEADING_ZERO_BLANK_EN
        if (m_idx == 1 && m_val / 10 == 0) m_seg = 7'h7F;
`endif
        tk      = (m_presc == 9);
        m_presc = (m_presc + 1) % 10;
        if (m_scan == 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % 2;
        end else begin
            m_scan = m_scan + 1;
        end
        if (load) m_val = clamp_load(load_value);
        else if (tk && enable && !m_finish()) m_val = m_val + (forward ? 1 : -1);
    endtask

    task automatic check_outputs();
        check("count",  32'(count),  32'(to_bcd(m_val)));
        check("finish", 32'(finish), 32'(m_finish()));
        check("an",     32'(an),     32'(m_an));
        check("seg",    32'(seg),    32'(m_seg));
        check("dp",     32'(dp),     32'd1);
    endtask

    // Inputs are driven at the negedge. The model steps on the posedge, and the bench checks at the next negedge.
    task automatic cycle();
        @(posedge clk_100MHz);
        if (reset) model_step();
        @(negedge clk_100MHz);
        check_outputs();
    endtask

    task automatic do_load(input logic [7:0] v);
        load       = 1'b1;
        load_value = v;
        cycle();
        load       = 1'b0;
    endtask

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;

        reset = 1'b0; enable = 1'b0; forward = 1'b1; load = 1'b0; load_value = 8'h00;
        model_reset();
        repeat (2) @(negedge clk_100MHz);
        check_outputs();
        check("reset_an",  32'(an),  32'h2);
        check("reset_seg", 32'(seg), 32'h40);
        reset = 1'b1;

        // Count up for 100 cycles: there are ten ticks, and 09 rolls over to 10.
        enable = 1'b1; forward = 1'b1;
        repeat (100) cycle();
        check("up100", 32'(count), 32'h10);

        // Saturate at 99, then reverse the direction.
        do_load(8'h97);
        repeat (40) cycle();
        check("sat99",     32'(count),  32'h99);
        check("sat99_fin", 32'(finish), 32'd1);
        forward = 1'b0;
        repeat (10) cycle();
        check("rev98",     32'(count),  32'h98);
        check("rev98_fin", 32'(finish), 32'd0);

        // Saturate at 00 while counting down. Counting down from 10 borrows to 09.
        do_load(8'h01);
        repeat (30) cycle();
        check("sat00",     32'(count),  32'h00);
        check("sat00_fin", 32'(finish), 32'd1);
        do_load(8'h10);
        repeat (10) cycle();
        check("borrow09", 32'(count), 32'h09);

        // Load on the tick cycle beats the increment. Non-BCD digits clamp to 9.
        forward = 1'b1;
        for (int k = 0; k < 20 && m_presc != 9; k++) cycle();
        check("tick_align", 32'(m_presc), 32'd9);
        do_load(8'h42);
        check("load_on_tick", 32'(count), 32'h42);
        do_load(8'hFA);
        check("load_clamp", 32'(count), 32'h99);

        // Assert reset asynchronously for one cycle in the middle of a count.
        do_load(8'h37);
        repeat (7) cycle();
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst_count", 32'(count), 32'h00);
        check("arst_an",    32'(an),    32'h2);
        check("arst_seg",   32'(seg),   32'h40);
        #9;
        reset = 1'b1;
        repeat (9) cycle();
        check("first_tick_pre", 32'(count), 32'h00);
        cycle();
        check("first_tick", 32'(count), 32'h01);

        // Scan a held count of 05.
        enable = 1'b0;
        do_load(8'h05);
        repeat (12) cycle();

        // Apply random stimulus and compare against the model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            enable     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 3) forward = ~forward;
            load       = ($urandom_range(0, 49) == 0);
            load_value = 8'($urandom);
            cycle();
        end
        load = 1'b0;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
